// File: rtl/clause_loader.sv
// clause_loader: assembles WORD_W stream words into clauses and writes them to a clause BRAM.
// Define CLAUSE_CHECKSUM_EN to add an XOR trailer check after the last clause.
module clause_loader #(
    parameter int IMG_WIDTH    = 32,
    parameter int IMG_HEIGHT   = 32,
    parameter int CLAUSEN      = 10,
    parameter int CLASSN       = 5,
    parameter int CLAUSE_WIDTH = (35 + IMG_HEIGHT + IMG_WIDTH) * 2,
    parameter int WORD_W       = 32,
    localparam int NWORDS      = (CLAUSE_WIDTH + WORD_W - 1) / WORD_W,
    localparam int ADDR_W      = $clog2(CLASSN * CLAUSEN)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [$clog2(CLAUSEN):0] clauses,
    input  logic                     coa,
    input  logic [WORD_W-1:0]        s_data,
    input  logic                     s_valid,
    output logic                     s_ready,
    output logic                     wea,
    output logic [ADDR_W-1:0]        bram_addr_a,
    output logic [CLAUSE_WIDTH-1:0]  clause_write,
    output logic                     busy,
    output logic                     load_done,
    output logic                     chk_err
);
    localparam int TOT_W = $clog2(CLASSN * CLAUSEN + 1);
    localparam int WC_W  = $clog2(NWORDS + 1);
    typedef enum logic [2:0] {
        IDLE, LOAD, WRITE,
`ifdef CLAUSE_CHECKSUM_EN
        CHECK,
`endif
        DONE
    } state_t;
`ifdef CLAUSE_CHECKSUM_EN
    localparam state_t FIN = CHECK;
    logic [WORD_W-1:0] acc_q, acc_d;
    logic chk_q, chk_d;
`else
    localparam state_t FIN = DONE;
`endif
    state_t state_q, state_d;
    logic [TOT_W-1:0] total_q, total_d, cnt_q, cnt_d, tot;
    logic [WC_W-1:0] wcnt_q, wcnt_d;
    logic [CLAUSE_WIDTH-1:0] asm_q, asm_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic wea_q, wea_d, rdy_q, rdy_d, busy_q, busy_d, done_q, done_d;
    logic take, last;

    always_comb begin
        tot = coa ? TOT_W'(clauses) : TOT_W'(CLASSN * clauses);
        take = s_valid && rdy_q;
        last = wcnt_q == WC_W'(NWORDS - 1);
        state_d = state_q;
        total_d = total_q;
        cnt_d = cnt_q;
        wcnt_d = wcnt_q;
        asm_d = asm_q;
`ifdef CLAUSE_CHECKSUM_EN
        acc_d = acc_q;
        chk_d = chk_q;
`endif
        case (state_q)
            IDLE: if (start) begin
                total_d = tot;
                cnt_d = '0;
                wcnt_d = '0;
`ifdef CLAUSE_CHECKSUM_EN
                acc_d = '0;
                chk_d = 1'b0;
`endif
                state_d = tot == '0 ? FIN : LOAD;
            end
            LOAD: if (take) begin
                // bits of the last word beyond CLAUSE_WIDTH fall off here
                for (int b = 0; b < CLAUSE_WIDTH; b++)
                    if (b / WORD_W == int'(wcnt_q)) asm_d[b] = s_data[b % WORD_W];
`ifdef CLAUSE_CHECKSUM_EN
                acc_d = acc_q ^ s_data;
`endif
                wcnt_d = last ? '0 : wcnt_q + 1'b1;
                state_d = last ? WRITE : LOAD;
            end
            WRITE: begin
                cnt_d = cnt_q + 1'b1;
                state_d = cnt_d < total_q ? LOAD : FIN;
            end
`ifdef CLAUSE_CHECKSUM_EN
            CHECK: if (take) begin
                chk_d = s_data != acc_q;
                state_d = DONE;
            end
`endif
            default: state_d = IDLE;
        endcase
        wea_d = state_d == WRITE;
        addr_d = wea_d ? ADDR_W'(cnt_d) : addr_q;
`ifdef CLAUSE_CHECKSUM_EN
        rdy_d = state_d == LOAD || state_d == CHECK;
`else
        rdy_d = state_d == LOAD;
`endif
        busy_d = state_d != IDLE;
        done_d = state_d == DONE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            total_q <= '0;
            cnt_q <= '0;
            wcnt_q <= '0;
            asm_q <= '0;
            addr_q <= '0;
            wea_q <= 1'b0;
            rdy_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
`ifdef CLAUSE_CHECKSUM_EN
            acc_q <= '0;
            chk_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            total_q <= total_d;
            cnt_q <= cnt_d;
            wcnt_q <= wcnt_d;
            asm_q <= asm_d;
            addr_q <= addr_d;
            wea_q <= wea_d;
            rdy_q <= rdy_d;
            busy_q <= busy_d;
            done_q <= done_d;
`ifdef CLAUSE_CHECKSUM_EN
            acc_q <= acc_d;
            chk_q <= chk_d;
`endif
        end
    end

    assign wea = wea_q;
    assign bram_addr_a = addr_q;
    assign clause_write = asm_q;
    assign s_ready = rdy_q;
    assign busy = busy_q;
    assign load_done = done_q;
`ifdef CLAUSE_CHECKSUM_EN
    assign chk_err = chk_q;
`else
    assign chk_err = 1'b0;
`endif
endmodule

// File: tb/tb_clause_loader.sv
// tb_clause_loader: randomized stream bench with a word-queue reference model for clause_loader.
module tb_clause_loader;
    localparam int CW = 198, WW = 32, NW = 7, AW = 6, CLASSN = 5;
`ifdef CLAUSE_CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif
    logic clk = 1'b0, rst = 1'b1, start = 1'b0, coa = 1'b0, s_valid = 1'b0;
    logic [4:0] clauses = '0;
    logic [WW-1:0] s_data = '0;
    logic s_ready, wea, busy, load_done, chk_err;
    logic [AW-1:0] bram_addr_a;
    logic [CW-1:0] clause_write;
    int n_chk = 0, n_bad = 0;
    logic [WW-1:0] words[$];
    int acc_cyc[$], wr_addr[$], wr_cyc[$];
    logic [CW-1:0] wr_data[$];
    int done_cyc;
    bit busy_after, chk_after, busy_drop, rdy_in_write, aborted;

    clause_loader dut (
        .clk(clk), .rst(rst), .start(start), .clauses(clauses), .coa(coa),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .wea(wea),
        .bram_addr_a(bram_addr_a), .clause_write(clause_write), .busy(busy),
        .load_done(load_done), .chk_err(chk_err)
    );

    always #5 clk = ~clk;

    function automatic logic [CW-1:0] model_clause(input int i);
        logic [NW*WW-1:0] w = '0;
        for (int k = 0; k < NW; k++) w[k*WW +: WW] = words[i*NW+k];
        return w[CW-1:0];
    endfunction

    function automatic logic [WW-1:0] xor_of(input int n);
        logic [WW-1:0] x = '0;
        for (int i = 0; i < n; i++) x ^= words[i];
        return x;
    endfunction

    // vmode: 0 continuous valid, 1 toggling 1,0,1,0, 2 random
    task automatic run_load(input int cl, input bit c, input int vmode, input bit flip,
                            input bit stray, input int abort_at);
        int cyc = 0;
        bit got = 0;
        int exp_tot = c ? cl : CLASSN * cl;
        words.delete(); acc_cyc.delete(); wr_addr.delete(); wr_cyc.delete(); wr_data.delete();
        done_cyc = -1; busy_drop = 0; rdy_in_write = 0; aborted = 0;
        @(negedge clk);
        clauses = 5'(cl); coa = c; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (!got && !aborted && cyc < 3000) begin
            if (abort_at >= 0 && words.size() == abort_at) begin
                rst = 1'b1; s_valid = 1'b0; aborted = 1;
                @(negedge clk);
                rst = 1'b0;
            end else begin
                if (!busy) busy_drop = 1;
                if (wea && s_ready) rdy_in_write = 1;
                if (load_done) begin got = 1; done_cyc = cyc; end
                if (wea) begin
                    wr_addr.push_back(int'(bram_addr_a));
                    wr_data.push_back(clause_write);
                    wr_cyc.push_back(cyc);
                end
                s_valid = vmode == 0 ? 1'b1 : vmode == 1 ? ~cyc[0] : 1'($urandom_range(0, 1));
                s_data = $urandom;
                if (CK && words.size() == exp_tot * NW) s_data = xor_of(exp_tot * NW) ^ WW'(flip);
                if (s_valid && s_ready) begin words.push_back(s_data); acc_cyc.push_back(cyc); end
                start = stray && s_ready && ($urandom_range(0, 2) == 0);
                if (start) begin clauses = 5'($urandom); coa = 1'($urandom); end
                @(negedge clk);
                cyc++;
            end
        end
        s_valid = 1'b0; start = 1'b0;
        busy_after = busy; chk_after = chk_err;
        if (!got && !aborted) begin
            n_chk++; n_bad++;
            $display("FAIL timeout: no load_done within %0d cycles", cyc);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_chk++;
        if ({busy, wea, s_ready, load_done, chk_err} !== 5'b0) begin
            n_bad++; $display("FAIL reset_flags got=%b exp=00000", {busy, wea, s_ready, load_done, chk_err});
        end
        n_chk++;
        if (bram_addr_a !== '0) begin n_bad++; $display("FAIL reset_addr got=%0h exp=0", bram_addr_a); end
        n_chk++;
        if (clause_write !== '0) begin n_bad++; $display("FAIL reset_data got=%0h exp=0", clause_write); end
        rst = 1'b0;
    endtask

    task automatic test_full();
        int exp_done;
        run_load(2, 0, 0, 0, 0, -1);
        n_chk++;
        if (wr_addr.size() != 10) begin n_bad++; $display("FAIL full_count got=%0d exp=10", wr_addr.size()); end
        for (int i = 0; i < wr_addr.size() && i < 10; i++) begin
            n_chk++;
            if (wr_addr[i] != i || wr_data[i] !== model_clause(i) || wr_cyc[i] != acc_cyc[i*NW+NW-1] + 1) begin
                n_bad++;
                $display("FAIL full_write[%0d] got addr=%0d cyc=%0d data=%0h exp addr=%0d cyc=%0d data=%0h",
                         i, wr_addr[i], wr_cyc[i], wr_data[i], i, acc_cyc[i*NW+NW-1] + 1, model_clause(i));
            end
        end
        exp_done = CK ? (acc_cyc.size() > 0 ? acc_cyc[$] + 1 : -2) : (wr_cyc.size() > 0 ? wr_cyc[$] + 1 : -2);
        n_chk++;
        if (done_cyc != exp_done) begin n_bad++; $display("FAIL full_done_cycle got=%0d exp=%0d", done_cyc, exp_done); end
        n_chk++;
        if (busy_after !== 1'b0 || busy_drop || rdy_in_write) begin
            n_bad++; $display("FAIL full_busy_ready got busy_after=%b drop=%b rdy_in_write=%b exp 0 0 0",
                              busy_after, busy_drop, rdy_in_write);
        end
    endtask

    task automatic test_coa_toggle();
        run_load(3, 1, 1, 0, 0, -1);
        n_chk++;
        if (wr_addr.size() != 3) begin n_bad++; $display("FAIL coa_count got=%0d exp=3", wr_addr.size()); end
        for (int i = 0; i < wr_addr.size() && i < 3; i++) begin
            n_chk++;
            if (wr_addr[i] != i || wr_data[i] !== model_clause(i)) begin
                n_bad++;
                $display("FAIL coa_write[%0d] got addr=%0d data=%0h exp addr=%0d data=%0h",
                         i, wr_addr[i], wr_data[i], i, model_clause(i));
            end
        end
    endtask

    task automatic test_zero();
        int exp_done;
        run_load(0, 0, 2, 0, 0, -1);
        n_chk++;
        if (wr_addr.size() != 0) begin n_bad++; $display("FAIL zero_count got=%0d exp=0", wr_addr.size()); end
        exp_done = CK ? (acc_cyc.size() > 0 ? acc_cyc[0] + 1 : -2) : 0;
        n_chk++;
        if (done_cyc != exp_done) begin n_bad++; $display("FAIL zero_done_cycle got=%0d exp=%0d", done_cyc, exp_done); end
        n_chk++;
        if (busy_after !== 1'b0) begin n_bad++; $display("FAIL zero_busy_fall got=%b exp=0", busy_after); end
    endtask

    task automatic test_abort();
        run_load(2, 0, 0, 0, 0, 4 * NW + 4);
        n_chk++;
        if (!aborted || {wea, busy, s_ready} !== 3'b0 || clause_write !== '0) begin
            n_bad++; $display("FAIL abort_state got aborted=%b wea/busy/rdy=%b data=%0h exp 1 000 0",
                              aborted, {wea, busy, s_ready}, clause_write);
        end
        n_chk++;
        if (wr_addr.size() != 4) begin n_bad++; $display("FAIL abort_writes got=%0d exp=4", wr_addr.size()); end
        run_load(1, 1, 0, 0, 0, -1);
        n_chk++;
        if (wr_addr.size() != 1 || (wr_addr.size() == 1 && (wr_addr[0] != 0 || wr_data[0] !== model_clause(0)))) begin
            n_bad++; $display("FAIL abort_reload got writes=%0d addr=%0d exp writes=1 addr=0", wr_addr.size(),
                              wr_addr.size() > 0 ? wr_addr[0] : -1);
        end
    endtask

    task automatic test_start_during_load();
        run_load(2, 1, 2, 0, 1, -1);
        n_chk++;
        if (wr_addr.size() != 2) begin n_bad++; $display("FAIL stray_count got=%0d exp=2", wr_addr.size()); end
        for (int i = 0; i < wr_addr.size() && i < 2; i++) begin
            n_chk++;
            if (wr_addr[i] != i || wr_data[i] !== model_clause(i)) begin
                n_bad++; $display("FAIL stray_write[%0d] got addr=%0d exp addr=%0d", i, wr_addr[i], i);
            end
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 6; r++) begin
            int cl = $urandom_range(0, 10);
            bit c = 1'($urandom);
            int et = c ? cl : CLASSN * cl;
            run_load(cl, c, 2, 0, 0, -1);
            n_chk++;
            if (wr_addr.size() != et || busy_after !== 1'b0 || busy_drop || chk_after !== 1'b0) begin
                n_bad++; $display("FAIL rand%0d_summary got writes=%0d busy_after=%b drop=%b chk=%b exp %0d 0 0 0",
                                  r, wr_addr.size(), busy_after, busy_drop, chk_after, et);
            end
            for (int i = 0; i < wr_addr.size() && i < et; i++) begin
                n_chk++;
                if (wr_addr[i] != i || wr_data[i] !== model_clause(i)) begin
                    n_bad++; $display("FAIL rand%0d_write[%0d] got addr=%0d data=%0h exp addr=%0d data=%0h",
                                      r, i, wr_addr[i], wr_data[i], i, model_clause(i));
                end
            end
        end
    endtask

    task automatic test_checksum();
        run_load(2, 1, 0, 1, 0, -1);
        n_chk++;
        if (chk_after !== CK) begin n_bad++; $display("FAIL chk_bad_trailer got=%b exp=%b", chk_after, CK); end
        repeat (5) @(negedge clk);
        n_chk++;
        if (chk_err !== CK) begin n_bad++; $display("FAIL chk_hold got=%b exp=%b", chk_err, CK); end
        run_load(2, 1, 2, 0, 0, -1);
        n_chk++;
        if (chk_after !== 1'b0) begin n_bad++; $display("FAIL chk_good_trailer got=%b exp=0", chk_after); end
    endtask

    initial begin
        test_reset();
        test_full();
        test_coa_toggle();
        test_zero();
        test_abort();
        test_start_during_load();
        test_random();
        test_checksum();
        test_reset();
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
